// File: rtl/spi_slave_resp.sv
// SPI responder: synchronises sck/mosi/ss_n into clk_i, deserialises MOSI bytes and shifts a
// preloaded TX byte out on MISO, MSB first, with valid/ready byte streams toward the fabric.
module spi_slave_resp #(
   parameter bit          CPOL        = 1'b0,
   parameter bit          CPHA        = 1'b0,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  DEFAULT_TX  = 8'hFF
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       sck_i,
   input  logic       mosi_i,
   input  logic       ss_n_i,
   output logic       miso_o,
   output logic       miso_oe_o,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic       overrun_o,
   output logic       underrun_o,
   output logic       busy_o
);

   localparam int unsigned SN = SYNC_STAGES;

   typedef enum logic [0:0] {StIdle, StActive} state_e;

   // One flop past the synchroniser so edges come from the last two synced sck samples;
   // mosi and ss_n are delayed to line up with the newer of those two samples.
   logic [SN+1:0] sck_pipe_q;
   logic [SN:0]   mosi_pipe_q;
   logic [SN:0]   ss_pipe_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sck_pipe_q  <= {(SN+2){CPOL}};
         mosi_pipe_q <= '0;
         ss_pipe_q   <= '1;
      end else begin
         sck_pipe_q  <= {sck_pipe_q[SN:0], sck_i};
         mosi_pipe_q <= {mosi_pipe_q[SN-1:0], mosi_i};
         ss_pipe_q   <= {ss_pipe_q[SN-1:0], ss_n_i};
      end
   end

   logic sck_s, sck_p, mosi_s, ss_s;
   logic lead_edge, trail_edge, sample_edge, shift_edge;

   assign sck_s       = sck_pipe_q[SN];
   assign sck_p       = sck_pipe_q[SN+1];
   assign mosi_s      = mosi_pipe_q[SN];
   assign ss_s        = ss_pipe_q[SN];
   assign lead_edge   = (sck_p == CPOL) && (sck_s != CPOL);
   assign trail_edge  = (sck_p != CPOL) && (sck_s == CPOL);
   assign sample_edge = CPHA ? trail_edge : lead_edge;
   assign shift_edge  = CPHA ? lead_edge : trail_edge;

   state_e     state_q, state_d;
   logic       miso_q, miso_d;
   logic       miso_oe_q, miso_oe_d;
   logic [7:0] hold_q, hold_d;
   logic       hold_full_q, hold_full_d;
   logic [7:0] tx_sh_q, tx_sh_d;
   logic [6:0] rx_sh_q, rx_sh_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       overrun_q, overrun_d;
   logic       underrun_q, underrun_d;
   logic       do_load;
   logic [7:0] load_byte;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         miso_q      <= 1'b0;
         miso_oe_q   <= 1'b0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         tx_sh_q     <= '0;
         rx_sh_q     <= '0;
         bit_cnt_q   <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         miso_q      <= miso_d;
         miso_oe_q   <= miso_oe_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         tx_sh_q     <= tx_sh_d;
         rx_sh_q     <= rx_sh_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         overrun_q   <= overrun_d;
         underrun_q  <= underrun_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      miso_d      = miso_q;
      miso_oe_d   = miso_oe_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      tx_sh_d     = tx_sh_q;
      rx_sh_d     = rx_sh_q;
      bit_cnt_d   = bit_cnt_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      overrun_d   = 1'b0;
      underrun_d  = 1'b0;
      do_load     = 1'b0;
      load_byte   = hold_full_q ? hold_q : DEFAULT_TX;

      if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;
      if (tx_valid_i && !hold_full_q) begin
         hold_d      = tx_data_i;
         hold_full_d = 1'b1;
      end

      // tx_sh_q[7] is always the next bit to present on a shift edge.
      unique case (state_q)
         StIdle: begin
            if (!ss_s) begin
               state_d   = StActive;
               do_load   = 1'b1;
               miso_oe_d = 1'b1;
               bit_cnt_d = '0;
               if (!CPHA) begin
                  miso_d  = load_byte[7];
                  tx_sh_d = {load_byte[6:0], 1'b0};
               end else begin
                  tx_sh_d = load_byte;
               end
            end
         end
         StActive: begin
            if (ss_s) begin
               state_d   = StIdle;
               miso_oe_d = 1'b0;
               bit_cnt_d = '0;
            end else if (sample_edge) begin
               rx_sh_d   = {rx_sh_q[5:0], mosi_s};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  if (!rx_valid_q || rx_ready_i) begin
                     rx_data_d  = {rx_sh_q, mosi_s};
                     rx_valid_d = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
                  do_load = 1'b1;
                  tx_sh_d = load_byte;
               end
            end else if (shift_edge) begin
               miso_d  = tx_sh_q[7];
               tx_sh_d = {tx_sh_q[6:0], 1'b0};
            end
         end
         default: state_d = StIdle;
      endcase

      if (do_load) begin
         if (hold_full_q) hold_full_d = 1'b0;
         else             underrun_d  = 1'b1;
      end
   end

   assign miso_o     = miso_q;
   assign miso_oe_o  = miso_oe_q;
   assign tx_ready_o = ~hold_full_q;
   assign rx_data_o  = rx_data_q;
   assign rx_valid_o = rx_valid_q;
   assign overrun_o  = overrun_q;
   assign underrun_o = underrun_q;
   assign busy_o     = (state_q == StActive);

endmodule

// File: tb/tb_spi_slave_resp.sv
// Bench for spi_slave_resp: a mode-0 and a mode-3 instance driven by a cycle-timed SPI master,
// checked by a table of transfers, hand sequences and randomized transfers against a byte model.
module tb_spi_slave_resp;
   localparam int unsigned SS    = 2;
   localparam int          H     = 8;
   localparam logic [7:0]  DFLT  = 8'hFF;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       sel, sck_m, mosi_m, ss_m;
   logic [7:0] tx_data;
   logic       tx_valid, rx_ready;

   logic       sck0, ss0, txv0, miso0, oe0, txr0, rxv0, ov0, un0, busy0;
   logic       sck3, ss3, txv3, miso3, oe3, txr3, rxv3, ov3, un3, busy3;
   logic [7:0] rxd0, rxd3;

   assign sck0 = sel ? 1'b0 : sck_m;
   assign ss0  = sel ? 1'b1 : ss_m;
   assign txv0 = tx_valid & ~sel;
   assign sck3 = sel ? sck_m : 1'b1;
   assign ss3  = sel ? ss_m : 1'b1;
   assign txv3 = tx_valid & sel;

   logic       miso, oe, txr, rxv, ov, un, busy;
   logic [7:0] rxd;
   assign miso = sel ? miso3 : miso0;
   assign oe   = sel ? oe3   : oe0;
   assign txr  = sel ? txr3  : txr0;
   assign rxv  = sel ? rxv3  : rxv0;
   assign ov   = sel ? ov3   : ov0;
   assign un   = sel ? un3   : un0;
   assign busy = sel ? busy3 : busy0;
   assign rxd  = sel ? rxd3  : rxd0;

   spi_slave_resp #(.CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(SS), .DEFAULT_TX(DFLT)) dut0 (
      .clk_i(clk), .rst_i(rst), .sck_i(sck0), .mosi_i(mosi_m), .ss_n_i(ss0),
      .miso_o(miso0), .miso_oe_o(oe0), .tx_data_i(tx_data), .tx_valid_i(txv0),
      .tx_ready_o(txr0), .rx_data_o(rxd0), .rx_valid_o(rxv0), .rx_ready_i(rx_ready),
      .overrun_o(ov0), .underrun_o(un0), .busy_o(busy0)
   );

   spi_slave_resp #(.CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(SS), .DEFAULT_TX(DFLT)) dut3 (
      .clk_i(clk), .rst_i(rst), .sck_i(sck3), .mosi_i(mosi_m), .ss_n_i(ss3),
      .miso_o(miso3), .miso_oe_o(oe3), .tx_data_i(tx_data), .tx_valid_i(txv3),
      .tx_ready_o(txr3), .rx_data_o(rxd3), .rx_valid_o(rxv3), .rx_ready_i(rx_ready),
      .overrun_o(ov3), .underrun_o(un3), .busy_o(busy3)
   );

   int n_chk = 0, n_fail = 0;
   int cyc = 0, samp_cyc = 0, rise_cyc = 0;
   int ov_cnt = 0, un_cnt = 0, rise_cnt = 0;
   logic rxv_prev = 1'b0;
   logic [7:0] got_rx[$], got_rd[$], exp_rx[$], exp_rd[$];

   // Reference model: TX holding register plus underrun tally.
   bit         m_full = 1'b0;
   logic [7:0] m_hold = '0;
   int         m_und  = 0;
   bit         mode3  = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (ov) ov_cnt++;
         if (un) un_cnt++;
         if (rxv && !rxv_prev) begin rise_cnt++; rise_cyc = cyc; end
         if (rxv && rx_ready) got_rx.push_back(rxd);
      end
      rxv_prev = rxv;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc_wait(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic m_load(output logic [7:0] b);
      if (m_full) begin m_full = 1'b0; b = m_hold; end
      else begin m_und++; b = DFLT; end
   endtask

   task automatic push(input logic [7:0] d);
      chk("tx_ready before push", {31'd0, txr}, 32'd1);
      tx_data = d; tx_valid = 1'b1;
      cyc_wait(1);
      tx_valid = 1'b0;
      m_full = 1'b1; m_hold = d;
   endtask

   task automatic set_mode(input bit m);
      sck_m = m; sel = m; mode3 = m;
      cyc_wait(2*H);
   endtask

   task automatic spi_bits(input logic [7:0] mo, input int n, input bit mid_en,
                           input logic [7:0] mid_d, output logic [7:0] mi);
      mi = '0;
      for (int i = 7; i > 7 - n; i--) begin
         if (!mode3) begin
            mosi_m = mo[i]; cyc_wait(H);
            sck_m = 1'b1; mi[i] = miso; samp_cyc = cyc; cyc_wait(H);
            sck_m = 1'b0;
         end else begin
            sck_m = 1'b0; mosi_m = mo[i]; cyc_wait(H);
            sck_m = 1'b1; mi[i] = miso; samp_cyc = cyc; cyc_wait(H);
         end
         if (mid_en && i == 5) push(mid_d);
      end
   endtask

   task automatic ss_low();
      logic [7:0] b;
      ss_m = 1'b0; cyc_wait(H);
      m_load(b); exp_rd.push_back(b);
      chk("miso_oe while selected", {31'd0, oe}, 32'd1);
      chk("busy while selected", {31'd0, busy}, 32'd1);
   endtask

   task automatic ss_high();
      logic [7:0] b;
      cyc_wait(H); ss_m = 1'b1; cyc_wait(2*H);
      b = exp_rd.pop_back();
      chk("miso_oe after deselect", {31'd0, oe}, 32'd0);
      chk("busy after deselect", {31'd0, busy}, 32'd0);
   endtask

   task automatic byte_x(input logic [7:0] mo, input bit mid_en, input logic [7:0] mid_d);
      logic [7:0] mi, b;
      spi_bits(mo, 8, mid_en, mid_d, mi);
      got_rd.push_back(mi); exp_rx.push_back(mo);
      m_load(b); exp_rd.push_back(b);
   endtask

   task automatic clear_q();
      got_rx.delete(); got_rd.delete(); exp_rx.delete(); exp_rd.delete();
   endtask

   task automatic cmp_model(input string tag, input int und_base, input int m_base);
      chk({tag, " read count"}, got_rd.size(), exp_rd.size());
      for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++)
         chk({tag, " master read"}, {24'd0, got_rd[i]}, {24'd0, exp_rd[i]});
      chk({tag, " rx count"}, got_rx.size(), exp_rx.size());
      for (int i = 0; i < got_rx.size() && i < exp_rx.size(); i++)
         chk({tag, " rx_data"}, {24'd0, got_rx[i]}, {24'd0, exp_rx[i]});
      chk({tag, " underruns"}, un_cnt - und_base, m_und - m_base);
      clear_q();
   endtask

   typedef struct {
      bit m3; bit pre; logic [7:0] pre_d; bit mid; logic [7:0] mid_d;
      logic [7:0] mo; logic [7:0] exp_rx; logic [7:0] exp_rd; int exp_und;
   } vec_t;

   initial begin
      vec_t vecs[5];
      int ub, rb, ob, mb, nb;
      logic [7:0] mi;
      vecs[0] = '{1'b0, 1'b1, 8'h3C, 1'b0, 8'h00, 8'hA5, 8'hA5, 8'h3C, 1};
      vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h12, 8'h12, 8'hFF, 1};
      vecs[2] = '{1'b1, 1'b1, 8'h7E, 1'b0, 8'h00, 8'h81, 8'h81, 8'h7E, 1};
      vecs[3] = '{1'b0, 1'b1, 8'h5A, 1'b1, 8'h99, 8'h0F, 8'h0F, 8'h5A, 0};
      vecs[4] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h44, 8'hC3, 8'hC3, 8'hFF, 1};

      rst = 1'b1; sel = 1'b0; sck_m = 1'b0; mosi_m = 1'b0; ss_m = 1'b1;
      tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b1;
      cyc_wait(3);
      chk("reset miso", {31'd0, miso}, 0);
      chk("reset miso_oe", {31'd0, oe}, 0);
      chk("reset tx_ready", {31'd0, txr}, 1);
      chk("reset rx_data", {24'd0, rxd}, 0);
      chk("reset rx_valid", {31'd0, rxv}, 0);
      chk("reset busy", {31'd0, busy}, 0);
      rst = 1'b0;
      cyc_wait(2*H);

      for (int v = 0; v < 5; v++) begin
         set_mode(vecs[v].m3);
         ub = un_cnt; clear_q();
         if (vecs[v].pre) push(vecs[v].pre_d);
         ss_low();
         byte_x(vecs[v].mo, vecs[v].mid, vecs[v].mid_d);
         cyc_wait(H);
         chk("rx_valid latency", rise_cyc - samp_cyc, SS + 2);
         ss_high();
         chk("vec master read", {24'd0, got_rd[0]}, {24'd0, vecs[v].exp_rd});
         chk("vec rx count", got_rx.size(), 1);
         if (got_rx.size() >= 1) chk("vec rx_data", {24'd0, got_rx[0]}, {24'd0, vecs[v].exp_rx});
         chk("vec underruns", un_cnt - ub, vecs[v].exp_und);
         clear_q();
      end

      // Overrun: two bytes with the consumer stalled.
      set_mode(1'b0);
      rx_ready = 1'b0; ob = ov_cnt;
      ss_low();
      byte_x(8'h01, 1'b0, 8'h00);
      byte_x(8'h02, 1'b0, 8'h00);
      ss_high();
      chk("overrun rx_data kept", {24'd0, rxd}, 32'h01);
      chk("overrun rx_valid held", {31'd0, rxv}, 1);
      chk("overrun pulses", ov_cnt - ob, 1);
      rx_ready = 1'b1;
      cyc_wait(2);
      chk("rx_valid drops after accept", {31'd0, rxv}, 0);
      chk("accepted count", got_rx.size(), 1);
      if (got_rx.size() >= 1) chk("accepted byte", {24'd0, got_rx[0]}, 32'h01);
      clear_q();

      // Abort after 4 bits, then a clean byte.
      rb = rise_cnt; ub = un_cnt; mb = m_und;
      ss_low();
      spi_bits(8'hF0, 4, 1'b0, 8'h00, mi);
      ss_high();
      chk("abort no rx_valid", rise_cnt - rb, 0);
      ss_low();
      byte_x(8'h55, 1'b0, 8'h00);
      ss_high();
      cmp_model("after abort", ub, mb);

      // Reset mid-byte with the holding register full.
      ss_low();
      spi_bits(8'hAA, 3, 1'b0, 8'h00, mi);
      push(8'hAB);
      chk("holding full", {31'd0, txr}, 0);
      rst = 1'b1;
      cyc_wait(1);
      chk("midreset miso", {31'd0, miso}, 0);
      chk("midreset miso_oe", {31'd0, oe}, 0);
      chk("midreset tx_ready", {31'd0, txr}, 1);
      chk("midreset rx_data", {24'd0, rxd}, 0);
      chk("midreset rx_valid", {31'd0, rxv}, 0);
      chk("midreset busy", {31'd0, busy}, 0);
      rst = 1'b0; ss_m = 1'b1; sck_m = 1'b0;
      m_full = 1'b0; clear_q();
      cyc_wait(2*H);
      rb = rise_cnt; ub = un_cnt; mb = m_und;
      chk("no rx_valid after reset", rise_cnt - rb, 0);
      ss_low();
      byte_x(8'hC3, 1'b0, 8'h00);
      ss_high();
      cmp_model("after reset", ub, mb);

      // Randomized transfers against the model.
      for (int t = 0; t < 20; t++) begin
         set_mode(1'($urandom_range(0, 1)));
         ub = un_cnt; mb = m_und;
         nb = $urandom_range(1, 3);
         if (!m_full && $urandom_range(0, 1) == 1) push(8'($urandom));
         ss_low();
         for (int k = 0; k < nb; k++)
            byte_x(8'($urandom), !m_full && ($urandom_range(0, 1) == 1), 8'($urandom));
         ss_high();
         cmp_model("random", ub, mb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
